// File: rtl/sum_accumulator_if.sv
// ---------------------------------------------------------------------------
// sum_accumulator_if
//
// Purpose:
//   Bundles the two valid/ready streams of the sum accumulator into a single
//   interface. The upstream side carries signed samples plus the frame
//   length. The downstream side carries the frame total and its saturation
//   flag.
//
// Signals:
//   in_data    IN_W    signed sample from the adder stage
//   in_valid   1       in_data valid
//   in_ready   1       accumulator can accept in_data this cycle
//   frame_len  CNT_W   samples per frame, taken on the first accept of a frame
//   out_data   OUT_W   signed frame total
//   out_valid  1       out_data valid
//   out_ready  1       downstream accepts out_data this cycle
//   out_sat    1       frame total was clamped somewhere in the frame
//
// Modports:
//   master  drives the samples and out_ready (producer / environment side)
//   slave   the accumulator itself
// ---------------------------------------------------------------------------
interface sum_accumulator_if #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 5,
    parameter int CNT_W = 4
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [CNT_W-1:0] frame_len;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sat;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        output frame_len,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_sat
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        input  frame_len,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_sat
    );
endinterface

// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//
// Purpose:
//   This block sits downstream of the 2-bit signed adder stage. It collects a
//   frame of signed samples over a valid/ready handshake. It adds them into
//   an OUT_W-bit running total. It then presents one frame total over a
//   second valid/ready handshake.
//
//   Frame flow:
//     IDLE  -> first accepted sample latches the frame length and seeds the
//              total. A frame of length 1 goes straight to HOLD.
//     ACCUM -> each accepted sample is added. The sample that completes the
//              frame moves to HOLD.
//     HOLD  -> the total is presented. Input is stalled until the
//              downstream side takes the total, then the block returns to
//              IDLE with everything cleared.
//   A frame_len of 0 is treated as 1. Later changes to frame_len within a
//   frame have no effect.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset. It drops any frame in flight.
//   bus    sum_accumulator_if.slave. It carries the sample stream
//          (in_data/in_valid/in_ready/frame_len) and the total stream
//          (out_data/out_valid/out_ready/out_sat).
//
// Configuration:
//   SUM_ACCUMULATOR_SAT_EN
//     Defined: every add clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and any
//     clamp raises a sticky out_sat for the frame.
//     Undefined (default): every add wraps in two's complement to OUT_W bits,
//     and out_sat stays 0.
// ---------------------------------------------------------------------------
module sum_accumulator #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 5,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sum_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // In the saturating build the adder is one bit wider than the result, so
    // overflow is visible before the clamp. The wrapping build only needs
    // OUT_W bits, because two's-complement wrap discards the carry anyway.
`ifdef SUM_ACCUMULATOR_SAT_EN
    localparam int SUM_W = OUT_W + 1;
`else
    localparam int SUM_W = OUT_W;
`endif

    state_t                  r_state;
    state_t                  w_nextState;

    logic signed [OUT_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        r_lenQ;
    logic                    r_sat;

    logic                    w_accept;
    logic                    w_deliver;
    logic [CNT_W-1:0]        w_lenEff;
    logic [CNT_W-1:0]        w_cntNext;
    logic                    w_lastSample;

    logic signed [OUT_W-1:0] w_base;
    logic signed [SUM_W-1:0] w_sampleExt;
    logic signed [SUM_W-1:0] w_baseExt;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [OUT_W-1:0] w_accNext;
    logic                    w_clamp;

    // Handshake events on both streams. HOLD is the only state that stalls
    // input. It is also the only state that offers output. So an accept and a
    // delivery can never happen in the same cycle.
    assign w_accept  = bus.in_valid & bus.in_ready;
    assign w_deliver = bus.out_valid & bus.out_ready;

    // A zero length is promoted to a single-sample frame, so every frame
    // produces exactly one total.
    assign w_lenEff  = (bus.frame_len == '0) ? CNT_W'(1) : bus.frame_len;
    assign w_cntNext = r_cnt + CNT_W'(1);

    // Decides whether the sample being accepted now closes the frame.
    // In IDLE the length has not been latched yet, so the live promoted
    // frame_len is used instead of r_lenQ.
    assign w_lastSample = (r_state == IDLE) ? (w_lenEff == CNT_W'(1))
                                            : (w_cntNext == r_lenQ);

    // The first sample of a frame starts from zero rather than from whatever
    // r_acc holds. r_acc is already cleared on delivery and on reset, but this
    // keeps the seed explicit.
    assign w_base      = (r_state == IDLE) ? '0 : r_acc;
    assign w_sampleExt = SUM_W'($signed(bus.in_data));
    assign w_baseExt   = SUM_W'(w_base);
    assign w_sum       = w_sampleExt + w_baseExt;

`ifdef SUM_ACCUMULATOR_SAT_EN
    localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

    // Range reduction with clamping. The sum left the OUT_W range exactly
    // when its two top bits disagree. The extra top bit then tells which
    // rail to clamp to.
    always_comb begin
        w_accNext = w_sum[OUT_W-1:0];
        w_clamp   = 1'b0;
        if (w_sum[SUM_W-1] != w_sum[SUM_W-2]) begin
            w_clamp   = 1'b1;
            w_accNext = w_sum[SUM_W-1] ? MIN_V : MAX_V;
        end
    end
`else
    // Range reduction by two's-complement wrap. The OUT_W-bit sum already
    // is the wrapped value, and nothing is ever flagged.
    assign w_accNext = w_sum;
    assign w_clamp   = 1'b0;
`endif

    // State register. Reset discards any partial frame or pending total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A frame ends on the accept that completes its sample
    // count, and it is released only by a downstream delivery.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_lastSample ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept && w_lastSample) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (w_deliver) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Accumulator datapath:
    //   - Gaps in in_valid leave acc and cnt untouched. There is no timeout.
    //   - The frame length is latched only on the first accept, which makes
    //     the frame immune to frame_len changes mid-frame.
    //   - The sticky saturation flag collects every clamp in the frame and is
    //     cleared together with the total when the total is delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_lenQ <= '0;
            r_sat  <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_accNext;
            r_sat <= r_sat | w_clamp;
            if (r_state == IDLE) begin
                r_cnt  <= CNT_W'(1);
                r_lenQ <= w_lenEff;
            end else begin
                r_cnt <= w_cntNext;
            end
        end else if (w_deliver) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end
    end

    // Output decode. in_ready is gated by rst_n, so it reads 0 for as long
    // as reset is held. It rises in the first cycle after release.
    // The total and the flag are only presented in HOLD. They stay put while
    // the downstream side stalls, because r_acc and r_sat cannot change in
    // HOLD.
    assign bus.in_ready  = rst_n & (r_state != HOLD);
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_data  = (r_state == HOLD) ? r_acc : '0;
    assign bus.out_sat   = (r_state == HOLD) & r_sat;

endmodule

// File: tb/tb_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sum_accumulator
//
// Purpose:
//   Testbench for sum_accumulator. It drives the sample stream and out_ready
//   through a sum_accumulator_if instance.
//   - A reference model tracks each frame as a plain integer count and
//     integer total. A compare process checks the DUT against the model on
//     every falling clock edge.
//   - Directed frames pin the model with hand-computed totals.
//   - Randomized traffic then exercises handshakes, frame lengths and
//     occasional resets.
// ---------------------------------------------------------------------------
module tb_sum_accumulator;

    localparam int IN_W  = 2;
    localparam int OUT_W = 5;
    localparam int CNT_W = 4;

`ifdef SUM_ACCUMULATOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int MAX_V = (1 << (OUT_W - 1)) - 1;
    localparam int MIN_V = -(1 << (OUT_W - 1));

    logic clk = 1'b0;
    logic rst_n;

    int tbTests = 0;
    int tbFails = 0;
    bit checkEn = 1'b0;

    sum_accumulator_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    sum_accumulator #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state: how many samples the current frame holds, its
    // fixed length, and its total. In the wrapping build the total is kept as
    // an exact integer and wrapped only when compared, since wrapping each
    // add gives the same result. mHold means a total is waiting for the
    // downstream side.
    int mCnt  = 0;
    int mLen  = 0;
    int mSum  = 0;
    bit mSat  = 1'b0;
    bit mHold = 1'b0;

    function automatic int clampInt(input int v);
        if (v > MAX_V) return MAX_V;
        if (v < MIN_V) return MIN_V;
        return v;
    endfunction

    function automatic int wrapInt(input int v);
        int m;
        m = v & ((1 << OUT_W) - 1);
        return (m > MAX_V) ? m - (1 << OUT_W) : m;
    endfunction

    function int sampleNow();
        return int'($signed(bus.in_data));
    endfunction

    // The frame length counts from the first sample. Zero means one.
    function int frameLenNow();
        if (mCnt != 0) return mLen;
        return (bus.frame_len == '0) ? 1 : int'(bus.frame_len);
    endfunction

    function int modelOut();
        return SAT ? mSum : wrapInt(mSum);
    endfunction

    // Model update at each rising edge. An accepted sample is counted and
    // added. A waiting total is dropped once taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mHold <= 1'b0;
            mCnt  <= 0;
            mLen  <= 0;
            mSum  <= 0;
            mSat  <= 1'b0;
        end else if (mHold) begin
            if (bus.out_ready) begin
                mHold <= 1'b0;
                mCnt  <= 0;
                mSum  <= 0;
                mSat  <= 1'b0;
            end
        end else if (bus.in_valid) begin
            mLen  <= frameLenNow();
            mCnt  <= mCnt + 1;
            mHold <= (mCnt + 1 == frameLenNow());
            mSum  <= SAT ? clampInt(mSum + sampleNow()) : mSum + sampleNow();
            mSat  <= mSat | (SAT && (clampInt(mSum + sampleNow()) != mSum + sampleNow()));
        end
    end

    // Compare the DUT against the model on every falling edge. Under reset,
    // all outputs must read zero.
    always @(negedge clk) begin
        if (checkEn) begin
            tbTests++;
            if (!rst_n) begin
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
                    bus.out_data !== '0 || bus.out_sat !== 1'b0) begin
                    tbFails++;
                    $display("[TB] FAIL model-reset: got ready=%b valid=%b data=%0d sat=%b, expected all 0",
                             bus.in_ready, bus.out_valid, $signed(bus.out_data), bus.out_sat);
                end
            end else if (bus.in_ready !== !mHold || bus.out_valid !== mHold ||
                         (mHold && (int'($signed(bus.out_data)) != modelOut() ||
                                    bus.out_sat !== (SAT & mSat)))) begin
                tbFails++;
                $display("[TB] FAIL model-compare @%0t: got ready=%b valid=%b data=%0d sat=%b, expected ready=%b valid=%b data=%0d sat=%b",
                         $time, bus.in_ready, bus.out_valid, $signed(bus.out_data), bus.out_sat,
                         !mHold, mHold, modelOut(), SAT & mSat);
            end
        end
    end

    // Step to just after the next falling edge. DUT outputs are settled there,
    // and a new input change lands well before the next rising edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Present one valid sample for one cycle.
    task automatic applyStimulus(input int len, input int val);
        bus.frame_len = CNT_W'(len);
        bus.in_data   = IN_W'(val);
        bus.in_valid  = 1'b1;
        tick();
    endtask

    // Literal check of the output stream. out_data and out_sat are only
    // compared when a total is expected to be on offer.
    task automatic checkOutput(input string name, input bit expValid, input int expData,
                               input bit expSat, input bit expReady);
        tbTests++;
        if (bus.out_valid !== expValid || bus.in_ready !== expReady ||
            (expValid && (int'($signed(bus.out_data)) != expData || bus.out_sat !== expSat))) begin
            tbFails++;
            $display("[TB] FAIL %s: got valid=%b ready=%b data=%0d sat=%b, expected valid=%b ready=%b data=%0d sat=%b",
                     name, bus.out_valid, bus.in_ready, $signed(bus.out_data), bus.out_sat,
                     expValid, expReady, expData, expSat);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.frame_len = '0;
        bus.out_ready = 1'b1;
        checkEn       = 1'b1;

        tick();
        checkOutput("reset-state", 1'b0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        checkOutput("ready-after-reset", 1'b0, 0, 1'b0, 1'b1);

        // Four samples summing to 2, taken on a single-cycle delivery.
        applyStimulus(4, 1);
        applyStimulus(4, 1);
        applyStimulus(4, -1);
        applyStimulus(4, 1);
        bus.in_valid = 1'b0;
        checkOutput("len4-total", 1'b1, 2, 1'b0, 1'b0);
        tick();
        checkOutput("len4-one-cycle", 1'b0, 0, 1'b0, 1'b1);

        // A zero frame length behaves as a single-sample frame.
        applyStimulus(0, -2);
        bus.in_valid = 1'b0;
        checkOutput("len0-as-1", 1'b1, -2, 1'b0, 1'b0);
        tick();

        // Largest frame: 15 x (+1) lands exactly on the positive rail.
        for (int i = 0; i < 15; i++) applyStimulus(15, 1);
        bus.in_valid = 1'b0;
        checkOutput("len15-plus", 1'b1, 15, 1'b0, 1'b0);
        tick();

        // 15 x (-2) = -30: it clamps to -16 or wraps to 2, depending on the build.
        for (int i = 0; i < 15; i++) applyStimulus(15, -2);
        bus.in_valid = 1'b0;
        checkOutput("len15-minus", 1'b1, SAT ? -16 : 2, SAT, 1'b0);
        tick();

        // Downstream stall: the total must hold, and input must stay blocked.
        bus.out_ready = 1'b0;
        applyStimulus(2, 1);
        applyStimulus(2, 1);
        bus.in_data = IN_W'(-2);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall-hold", 1'b1, 2, 1'b0, 1'b0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("stall-deliver-cycle", 1'b1, 2, 1'b0, 1'b0);
        tick();
        checkOutput("stall-released", 1'b0, 0, 1'b0, 1'b1);

        // Gaps in in_valid with garbage data: only the three accepted samples count.
        applyStimulus(3, 1);
        bus.in_valid = 1'b0;
        bus.in_data  = IN_W'(-2);
        tick();
        applyStimulus(3, 1);
        bus.in_valid = 1'b0;
        bus.in_data  = IN_W'(-2);
        tick();
        applyStimulus(3, -1);
        bus.in_valid = 1'b0;
        checkOutput("gapped-total", 1'b1, 1, 1'b0, 1'b0);
        tick();

        // Reset in the middle of a frame. The next frame starts clean.
        applyStimulus(4, 1);
        applyStimulus(4, 1);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midframe-reset", 1'b0, 0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        applyStimulus(2, 1);
        applyStimulus(2, 1);
        bus.in_valid = 1'b0;
        checkOutput("post-reset-total", 1'b1, 2, 1'b0, 1'b0);
        tick();

        // Randomized traffic checked cycle by cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(0, 499) != 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = IN_W'($urandom);
            bus.frame_len = ($urandom_range(0, 7) == 0) ? CNT_W'(15)
                                                         : CNT_W'($urandom_range(0, 4));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tbTests, tbFails);
        $finish;
    end

endmodule
